// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: queue entry layout,
// fetch state encoding and the default filler instruction.
package fetch_pkg;

   localparam int unsigned FETCH_XLEN = 32;
   localparam int unsigned FETCH_ILEN = 32;

   localparam logic [FETCH_ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] npc;
      logic [FETCH_ILEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear, used for the prefetch queue
// and for the pending fetch-address list.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // A full FIFO may still accept a write when the head leaves this cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= nxt(wr_ptr);
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// Sequential instruction fetch with credit-limited memory requests,
// a prefetch queue toward decode and redirect-driven flushing.
module fetch_queue_unit
   import fetch_pkg::fetch_entry_t, fetch_pkg::fetch_state_e,
          fetch_pkg::RUN, fetch_pkg::FLUSH;
#(
   parameter int unsigned     XLEN            = 32,
   parameter int unsigned     ILEN            = 32,
   parameter int unsigned     DEPTH           = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
   parameter logic [ILEN-1:0] NOP_INSTR       = fetch_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_npc,
   output logic [ILEN-1:0] dec_instr,
   output logic            busy
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   fetch_state_e    state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] pend_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   discard;
   logic [OW-1:0]   discard_next;
   logic [CW-1:0]   count;
   logic            q_empty;
   logic            q_full;
   logic            a_empty;
   logic            a_full;
   logic            rsp;
   logic            req;
   logic            fire;
   fetch_entry_t    q_din;
   fetch_entry_t    q_dout;
   logic            unused_bits;

   // The pending-address list length is the in-flight request count.
   assign rsp  = imem_rvalid && !a_empty;
   assign req  = !rst && (state == RUN) && !redirect_valid && !a_full
              && (32'(count) + 32'(outstanding) < DEPTH);
   assign fire = req && imem_gnt;

   assign discard_next = outstanding - OW'(rsp);

   always_comb begin
      q_din       = '0;
      q_din.pc    = pend_pc;
      q_din.npc   = pend_pc + XLEN'(4);
      q_din.instr = imem_rdata;
   end

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTSTANDING)
   ) u_pend (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .push  (fire),
      .din   (fetch_pc),
      .pop   (rsp),
      .dout  (pend_pc),
      .full  (a_full),
      .empty (a_empty),
      .count (outstanding)
   );

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect_valid),
      .push  (rsp && (discard == '0)),
      .din   (q_din),
      .pop   (dec_valid && dec_ready),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         discard  <= discard_next;
         state    <= (discard_next != '0) ? FLUSH : RUN;
      end else begin
         if (fire) fetch_pc <= fetch_pc + XLEN'(4);
         if (rsp && (discard != '0)) begin
            discard <= discard - OW'(1);
            if (discard == OW'(1)) state <= RUN;
         end
      end
   end

   assign imem_req  = req;
   assign imem_addr = fetch_pc;
   assign dec_valid = !q_empty;
   assign dec_pc    = dec_valid ? q_dout.pc : fetch_pc;
   assign dec_npc   = dec_valid ? q_dout.npc : fetch_pc + XLEN'(4);
   assign dec_instr = dec_valid ? q_dout.instr : NOP_INSTR;
   assign busy      = !a_empty || dec_valid;

   assign unused_bits = ^{q_full, redirect_pc[1:0]};

`ifndef SYNTHESIS
   a_rsp_expected: assert property (
      @(posedge clk) disable iff (rst) !(imem_rvalid && a_empty)
   ) else $error("imem_rvalid with no request in flight");
`endif

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised next-generation instruction fetch stage.
- Issues sequential fetch requests to instruction memory over a request/grant/response handshake, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions with their PC and next PC in a DEPTH-entry prefetch queue, then presents them to decode under valid/ready.
- Branch redirects flush the queue and discard stale in-flight responses.

Parameters:
- XLEN, 32, address/PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, prefetch queue entries (power of 2, ≥2).
- MAX_OUTSTANDING, 2, maximum in-flight memory requests (≥1, ≤DEPTH).
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INSTR, 32'h00000013, instruction driven when the output is not valid.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; responses return in request order.
- imem_rdata  in  ILEN  response instruction.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  XLEN  redirect target.
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decode accepts head.
- dec_pc  out  XLEN  PC of head instruction.
- dec_npc  out  XLEN  dec_pc+4.
- dec_instr  out  ILEN  head instruction, or NOP_INSTR when !dec_valid.
- busy  out  1  outstanding≠0 or queue non-empty.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; discard=0; state=RUN.
  - Outputs: dec_valid=0, dec_instr=NOP_INSTR, dec_pc=RESET_PC, dec_npc=RESET_PC+4, imem_req=0, busy=0.
  - Reset mid-operation abandons in-flight requests; responses arriving after reset are ignored because outstanding=0.
- Credit rule: imem_req=1 only when all of the following hold:
  - state==RUN
  - !redirect_valid
  - outstanding<MAX_OUTSTANDING
  - count+outstanding<DEPTH
- Addressing: imem_addr=fetch_pc. On req&&gnt: fetch_pc+=4 (wraps modulo 2^XLEN) and the address is pushed to a pending-address FIFO (depth MAX_OUTSTANDING). imem_req/imem_addr may change without a grant.
- Response handling: on imem_rvalid with outstanding>0, pop the pending address.
  - discard>0: drop the data; discard-=1.
  - discard==0: write {pc, pc+4, rdata} into the queue.
  - outstanding is incremented by grant and decremented by response; a simultaneous grant and response leaves it unchanged.
- Latency: an instruction is visible on dec_* in the cycle after its imem_rvalid. There is no bypass.
- Output handshake:
  - dec_valid = queue non-empty.
  - An entry pops on dec_valid&&dec_ready.
  - Head outputs are stable while dec_valid&&!dec_ready.
  - A pop and a push in the same cycle are allowed when the queue is full; the credit rule already prevents overflow.
- Redirect (highest priority):
  - Queue cleared; fetch_pc=redirect_pc with bits[1:0] forced to 0.
  - discard = outstanding minus 1 if a response arrives that same cycle (that response is itself dropped).
  - No request is issued in the redirect cycle.
  - Next state is FLUSH if the new discard>0, else RUN.
  - A redirect during FLUSH re-applies the same rule.
- FSM:
  - RUN → FLUSH on a redirect that leaves discards pending.
  - FLUSH: no requests; stays until discard reaches 0, then returns to RUN. The response that completes the last discard is dropped, and requests resume the following cycle.
- imem_rvalid with outstanding==0 is a protocol error: ignored, with a simulation-only assertion.
- Pending-address FIFO and queue pointers wrap modulo their depth.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t struct {pc, npc, instr}
  - fetch_state_e {RUN, FLUSH}
  - NOP_INSTR constant
- Sub-module fetch_fifo, parametrised by width and depth, with push/pop/clear/full/empty/count.
  - Instantiated twice: once as the prefetch queue of fetch_entry_t, once as the pending-address FIFO.
- FSM and credit logic stay in the top level.

Test Plan:
- Reset release, imem_gnt=1, one-cycle responses of 0xA0..., dec_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - dec_pc 0x0 appears two cycles after the first request, with dec_npc=0x4.
- dec_ready=0 held with DEPTH=4, MAX_OUTSTANDING=2:
  - At most 4 entries are fetched; imem_req=0 once count+outstanding=4.
  - The head stays PC 0x0 and is stable until ready rises.
- Two requests outstanding, redirect_pc=0x103:
  - fetch_pc=0x100; both stale responses are dropped (state FLUSH for 2 responses).
  - The first dec_pc after the redirect is 0x100.
- Redirect in the same cycle as a response with outstanding=1:
  - That response is dropped, discard=0, state stays RUN.
  - A request to the new PC is issued next cycle.
- Wrap: RESET_PC=32'hFFFFFFF8:
  - Addresses FFFFFFF8, FFFFFFFC, 00000000.
  - dec_npc of the FFFFFFFC entry is 0x0.
- rst asserted with requests in flight:
  - Outputs return to reset values next cycle; a late imem_rvalid produces no dec_valid.
